// File: rtl/wb_fifo_slave_if.sv
// Wishbone-style slave bus for the FIFO block: strobe/address/direction/data
// from the master, one-cycle acknowledge and read data back.
interface wb_fifo_slave_if;
    logic       wb_stbi;
    logic [7:0] wb_adri;
    logic       wb_rwi;
    logic [7:0] wb_dati;
    logic       wb_acko;
    logic [7:0] wb_dato;

    modport master (
        output wb_stbi, wb_adri, wb_rwi, wb_dati,
        input  wb_acko, wb_dato
    );

    modport slave (
        input  wb_stbi, wb_adri, wb_rwi, wb_dati,
        output wb_acko, wb_dato
    );
endinterface

// File: rtl/wb_fifo_slave.sv
// Bus-mapped TX/RX byte FIFO pair with programmable wait states, sticky
// overflow/underflow flags, flush and a registered interrupt.
module wb_fifo_slave #(
    parameter logic [7:0] BASE        = 8'h10,
    parameter int         WAIT_STATES = 1,
    parameter int         DEPTH       = 8
) (
    input  logic              clk,
    input  logic              rst,
    wb_fifo_slave_if.slave    bus,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              irq
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

    state_t     state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       enter_ack;
    logic       hit;

    logic [1:0] ctrl_reg;
    logic       tx_ovf_reg, rx_udf_reg, rx_ovf_reg;
    logic       rd_empty_reg;
    logic [7:0] dato_reg;
    logic       irq_reg;

    // index 0 = TX FIFO (bus pushes, consumer pops), 1 = RX FIFO (producer pushes, bus pops)
    logic [1:0]       push_req, pop_req, push_ok, pop_ok, full, empty;
    logic [1:0][7:0]  push_data, head;
    logic [1:0][3:0]  count;

    logic [1:0] reg_sel;
    logic       ack_cycle, bus_wr, bus_rd;
    logic       flush, status_wr, ctrl_wr, data_rd;
    logic [7:0] status_val, rd_mux;

    assign hit       = bus.wb_stbi && (bus.wb_adri[7:2] == BASE[7:2]);
    assign reg_sel   = bus.wb_adri[1:0];
    assign ack_cycle = (state_reg == S_ACK);
    assign bus_wr    = ack_cycle && bus.wb_rwi;
    assign bus_rd    = ack_cycle && !bus.wb_rwi;
    assign flush     = bus_wr && (reg_sel == 2'd2) && bus.wb_dati[7];
    assign ctrl_wr   = bus_wr && (reg_sel == 2'd2);
    assign status_wr = bus_wr && (reg_sel == 2'd1);
    assign data_rd   = bus_rd && (reg_sel == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        enter_ack     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (hit) begin
                    if (WAIT_STATES == 0) begin
                        state_next = S_ACK;
                        enter_ack  = 1'b1;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = 4'd0;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.wb_stbi) begin
                    state_next = S_IDLE;
                end else if (wait_cnt_reg == WS_LAST) begin
                    state_next = S_ACK;
                    enter_ack  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            S_ACK:  state_next = S_HOLD;
            S_HOLD: if (!bus.wb_stbi) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign push_req[0]  = bus_wr && (reg_sel == 2'd0);
    assign push_data[0] = bus.wb_dati;
    assign pop_req[0]   = tx_ready;
    assign push_req[1]  = rx_valid;
    assign push_data[1] = rx_data;
    // the bus pop follows what was returned on entry to ACK, not the live count
    assign pop_req[1]   = data_rd && !rd_empty_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0] mem [DEPTH];
            logic [2:0] wr_ptr_reg, rd_ptr_reg;
            logic [3:0] count_reg;

            assign full[gi]    = (count_reg == FULL_COUNT);
            assign empty[gi]   = (count_reg == 4'd0);
            assign push_ok[gi] = push_req[gi] && !full[gi];
            assign pop_ok[gi]  = pop_req[gi] && !empty[gi];
            assign head[gi]    = mem[rd_ptr_reg];
            assign count[gi]   = count_reg;

            always_ff @(posedge clk) begin
                if (push_ok[gi] && !flush)
                    mem[wr_ptr_reg] <= push_data[gi];
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    wr_ptr_reg <= 3'd0;
                    rd_ptr_reg <= 3'd0;
                    count_reg  <= 4'd0;
                end else begin
                    if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 3'd1;
                    if (pop_ok[gi])  rd_ptr_reg <= rd_ptr_reg + 3'd1;
                    count_reg <= count_reg + {3'd0, push_ok[gi]} - {3'd0, pop_ok[gi]};
                end
            end
        end
    endgenerate

    assign status_val = {1'b0, rx_ovf_reg, rx_udf_reg, tx_ovf_reg,
                         empty[1], full[1], empty[0], full[0]};

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            2'd0: rd_mux = empty[1] ? 8'h00 : head[1];
            2'd1: rd_mux = status_val;
            2'd2: rd_mux = {6'd0, ctrl_reg};
            2'd3: rd_mux = {count[1], count[0]};
            default: rd_mux = 8'h00;
        endcase
    end

    // a flag being set on the same edge as its clear wins, so no event is lost
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg     <= 2'd0;
            tx_ovf_reg   <= 1'b0;
            rx_udf_reg   <= 1'b0;
            rx_ovf_reg   <= 1'b0;
            rd_empty_reg <= 1'b0;
            dato_reg     <= 8'h00;
            irq_reg      <= 1'b0;
        end else begin
            if (enter_ack) begin
                dato_reg     <= rd_mux;
                rd_empty_reg <= empty[1];
            end
            if (ctrl_wr) ctrl_reg <= bus.wb_dati[1:0];

            if (push_req[0] && full[0])                 tx_ovf_reg <= 1'b1;
            else if (status_wr && bus.wb_dati[4])       tx_ovf_reg <= 1'b0;
            if (data_rd && rd_empty_reg)                rx_udf_reg <= 1'b1;
            else if (status_wr && bus.wb_dati[5])       rx_udf_reg <= 1'b0;
            if (push_req[1] && full[1])                 rx_ovf_reg <= 1'b1;
            else if (status_wr && bus.wb_dati[6])       rx_ovf_reg <= 1'b0;

            irq_reg <= (ctrl_reg[0] && !empty[1]) || (ctrl_reg[1] && empty[0]);
        end
    end

    assign bus.wb_acko = ack_cycle;
    assign bus.wb_dato = dato_reg;
    assign tx_valid    = !empty[0];
    assign tx_data     = empty[0] ? 8'h00 : head[0];
    assign irq         = irq_reg;

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Directed bench for wb_fifo_slave (BASE=8'h10, WAIT_STATES=1): register map,
// FIFO boundaries, flags, flush, irq, decode miss and reset abort.
module tb_wb_fifo_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       irq;

    int n_checks = 0;
    int n_pass   = 0;

    wb_fifo_slave_if bus ();

    wb_fifo_slave #(.BASE(8'h10), .WAIT_STATES(1), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // One bus transaction; expects ACK exactly 2 cycles after stb is driven.
    task automatic xfer(input logic [7:0] adr, input logic rw, input logic [7:0] wdat,
                        input logic pop_at_ack, output logic [7:0] rdat);
        int   lat;
        logic seen;
        @(posedge clk); #1;
        bus.wb_stbi = 1'b1;
        bus.wb_adri = adr;
        bus.wb_rwi  = rw;
        bus.wb_dati = wdat;
        lat  = 0;
        seen = 1'b0;
        rdat = 8'h00;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.wb_acko) begin
                seen = 1'b1;
                rdat = bus.wb_dato;
            end
        end
        check("ack_latency", lat, 2);
        if (pop_at_ack) tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("ack_one_cycle", {31'd0, bus.wb_acko}, 0);
        check("dato_hold", {24'd0, bus.wb_dato}, {24'd0, rdat});
        bus.wb_stbi = 1'b0;
        @(posedge clk); #1;
        $display("xfer adr=%h rw=%b wdat=%h rdat=%h lat=%0d", adr, rw, wdat, rdat, lat);
    endtask

    task automatic wr(input logic [7:0] adr, input logic [7:0] d);
        logic [7:0] dummy;
        xfer(adr, 1'b1, d, 1'b0, dummy);
    endtask

    task automatic rd(input logic [7:0] adr, output logic [7:0] d);
        xfer(adr, 1'b0, 8'h00, 1'b0, d);
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] exp_q [3];
        int         acks;

        rst = 1'b1;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        bus.wb_stbi = 1'b0; bus.wb_adri = 8'h00; bus.wb_rwi = 1'b0; bus.wb_dati = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acko", {31'd0, bus.wb_acko}, 0);
        check("rst_dato", {24'd0, bus.wb_dato}, 0);
        check("rst_tx_valid", {31'd0, tx_valid}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_irq", {31'd0, irq}, 0);
        rst = 1'b0;
        rd(8'h11, r); check("rst_status", {24'd0, r}, 32'h0A);

        // single write reaches the TX head
        wr(8'h10, 8'hA5);
        check("tx_valid_a5", {31'd0, tx_valid}, 1);
        check("tx_data_a5", {24'd0, tx_data}, 32'hA5);
        rd(8'h13, r); check("level_1", {24'd0, r}, 32'h01);
        tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
        check("tx_drained", {31'd0, tx_valid}, 0);

        // overflow TX with one entry parked in RX
        rx_push(8'h3C);
        for (int i = 0; i < 9; i++) wr(8'h10, 8'(i));
        rd(8'h11, r); check("status_txovf", {24'd0, r}, 32'h11);
        check("tx_head_after_ovf", {24'd0, tx_data}, 32'h00);
        wr(8'h11, 8'h10);
        rd(8'h11, r); check("status_clr", {24'd0, r}, 32'h01);

        // rx-not-empty irq, pop, then underflow
        wr(8'h12, 8'h01);
        check("irq_on", {31'd0, irq}, 1);
        rd(8'h10, r); check("rx_pop_data", {24'd0, r}, 32'h3C);
        check("irq_off", {31'd0, irq}, 0);
        rd(8'h10, r); check("rx_udf_data", {24'd0, r}, 32'h00);
        rd(8'h11, r); check("status_udf", {24'd0, r}, 32'h29);

        // flush both FIFOs, CTRL readback, tx-empty irq
        wr(8'h12, 8'h83);
        rd(8'h13, r); check("level_flush", {24'd0, r}, 32'h00);
        rd(8'h12, r); check("ctrl_read", {24'd0, r}, 32'h03);
        check("irq_tx_empty", {31'd0, irq}, 1);
        wr(8'h12, 8'h00);

        // simultaneous bus push and consumer pop at 3 entries
        wr(8'h10, 8'h11); wr(8'h10, 8'h22); wr(8'h10, 8'h33);
        xfer(8'h10, 1'b1, 8'h44, 1'b1, r);
        rd(8'h13, r); check("level_push_pop", {24'd0, r}, 32'h03);
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            check("tx_order", {24'd0, tx_data}, {24'd0, exp_q[i]});
            tx_ready = 1'b1; @(posedge clk); #1; tx_ready = 1'b0;
        end
        check("tx_empty_after_order", {31'd0, tx_valid}, 0);

        // RX overflow, then flush leaves the sticky flags alone
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'(8'h50 + i);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rd(8'h11, r); check("status_rxovf", {24'd0, r}, 32'h66);
        rd(8'h13, r); check("level_rx_full", {24'd0, r}, 32'h80);
        rd(8'h10, r); check("rx_first_kept", {24'd0, r}, 32'h50);
        wr(8'h12, 8'h80);
        rd(8'h13, r); check("level_flush2", {24'd0, r}, 32'h00);
        rd(8'h11, r); check("flags_survive_flush", {24'd0, r}, 32'h6A);
        wr(8'h11, 8'h70);
        rd(8'h11, r); check("flags_cleared", {24'd0, r}, 32'h0A);

        // address outside the block: no ACK
        @(posedge clk); #1;
        bus.wb_stbi = 1'b1; bus.wb_adri = 8'h20; bus.wb_rwi = 1'b1; bus.wb_dati = 8'h99;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (bus.wb_acko) acks++;
        end
        check("no_ack_miss", acks, 0);
        check("no_push_miss", {31'd0, tx_valid}, 0);
        bus.wb_stbi = 1'b0;
        @(posedge clk); #1;

        // reset during WAIT aborts, held stb then restarts from IDLE
        bus.wb_stbi = 1'b1; bus.wb_adri = 8'h10; bus.wb_rwi = 1'b1; bus.wb_dati = 8'h77;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_acko", {31'd0, bus.wb_acko}, 0);
        check("abort_no_push", {31'd0, tx_valid}, 0);
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 2; i++) begin
            check("restart_no_early_ack", {31'd0, bus.wb_acko}, 0);
            @(posedge clk); #1;
        end
        check("restart_ack", {31'd0, bus.wb_acko}, 1);
        @(posedge clk); #1;
        bus.wb_stbi = 1'b0;
        check("restart_push", {24'd0, tx_data}, 32'h77);
        @(posedge clk); #1;
        rd(8'h13, r); check("restart_level", {24'd0, r}, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_fifo_slave.md
WB_FIFO_SLAVE -- requirements
Module: wb_fifo_slave

Interface
REQ-001 SHALL have parameter BASE, default 8'h10, block base address; the block decodes wb_adri[7:2] == BASE[7:2].
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles before ACK; legal range 0..12.
REQ-003 SHALL have parameter DEPTH, default 8, entries per FIFO; fixed at 8.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wb_stbi  in  1  wishbone strobe, held high until ACK is sampled.
REQ-007 wb_adri  in  8  wishbone address.
REQ-008 wb_rwi  in  1  1 = write, 0 = read.
REQ-009 wb_dati  in  8  write data.
REQ-010 wb_acko  out  1  one-cycle acknowledge.
REQ-011 wb_dato  out  8  read data, valid while wb_acko = 1.
REQ-012 tx_data  out  8  TX FIFO head.
REQ-013 tx_valid  out  1  TX FIFO non-empty.
REQ-014 tx_ready  in  1  local consumer accepts tx_data.
REQ-015 rx_data  in  8  local producer data.
REQ-016 rx_valid  in  1  push rx_data into RX FIFO this cycle.
REQ-017 irq  out  1  registered interrupt, active-high.

Function
REQ-018 Register map by wb_adri[1:0]:
- 0 DATA: a write pushes the TX FIFO; a read pops the RX FIFO.
- 1 STATUS: read {0, rx_ovf, rx_udf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full}, bit7 down to bit0; a write-1 to bits 4..6 clears the matching flag.
- 2 CTRL: r/w; bit0 enables the rx-not-empty irq, bit1 enables the tx-empty irq, bits 6..2 read 0; bit7 is write-only flush and self-clears.
- 3 LEVEL: read {rx_count[3:0], tx_count[3:0]}; writes are ignored.
REQ-019 Bus FSM states:
- IDLE: on decoded stb, go to WAIT if WAIT_STATES > 0, else go to ACK.
- WAIT: count WAIT_STATES cycles, then go to ACK.
- ACK: wb_acko = 1 for exactly one cycle, then go to HOLD.
- HOLD: go to IDLE when wb_stbi = 0.
REQ-020 Latency: wb_acko SHALL assert 1 + WAIT_STATES cycles after the first edge at which decoded wb_stbi is sampled high.
REQ-021 Side effects (push, pop, flag clear, CTRL write) SHALL occur exactly once per transaction, at the clock edge that ends the ACK cycle.
REQ-022 wb_dato SHALL be registered on entry to ACK and SHALL hold its value until the next transaction.
REQ-023 If the address does not decode, the block SHALL NOT assert wb_acko; the FSM stays in IDLE.
REQ-024 If wb_stbi drops during WAIT, the FSM SHALL return to IDLE with no ACK and no side effect.
REQ-025 DATA write while the TX FIFO is full: data dropped, tx_ovf set, ACK still given.
REQ-026 DATA read while the RX FIFO is empty: wb_dato = 8'h00, rx_udf set, no pop.
REQ-027 rx_valid while the RX FIFO is full: data dropped, rx_ovf set.
REQ-028 TX pop occurs when tx_valid & tx_ready; tx_data is the head entry, first-word fall-through.
REQ-029 Full/empty conditions SHALL be evaluated on the pre-edge count:
- simultaneous push and pop on a non-full, non-empty FIFO: count unchanged;
- push while full: dropped even if a pop occurs the same cycle;
- pop while empty: no-op even if a push occurs the same cycle.
REQ-030 Pointers SHALL be 3 bits, wrap modulo 8; counts SHALL be 4 bits, range 0..8.
REQ-031 Flush SHALL empty both FIFOs (pointers and counts to 0) and SHALL take priority over same-cycle pushes and pops; overflow/underflow flags are unaffected.
REQ-032 irq SHALL be registered as (ctrl[0] & !rx_empty) | (ctrl[1] & tx_empty).

Reset
REQ-033 On rst:
- FSM to IDLE; wb_acko = 0; wb_dato = 8'h00.
- Both FIFOs empty; tx_valid = 0; tx_data = 8'h00.
- CTRL = 0; all flags = 0; irq = 0.
REQ-034 rst asserted mid-transaction SHALL abort it with no side effect; after rst releases, an unbroken high stb starts a new transaction from IDLE.
REQ-035 FIFO storage contents need not be reset.

Verification
REQ-036 WAIT_STATES=1, BASE=8'h10: write 8'hA5 to 8'h10 -> wb_acko high 2 cycles after stb; tx_valid=1, tx_data=8'hA5; LEVEL reads 8'h01.
REQ-037 Write 9 bytes to DATA with tx_ready=0 -> STATUS reads 8'h11 (tx_ovf, tx_full); write 8'h10 to STATUS -> STATUS reads 8'h01.
REQ-038 Push 8'h3C via rx_valid, CTRL=8'h01 -> irq=1; read 8'h10 -> wb_dato=8'h3C during ACK, irq=0 afterwards; a second read -> 8'h00, rx_udf=1.
REQ-039 TX FIFO holds 3 entries; same-cycle bus push and tx_ready pop -> count stays 3, order preserved; write 8'h80 to CTRL -> LEVEL reads 8'h00.
REQ-040 Access to 8'h20 -> no ACK for 16 cycles; assert rst during WAIT -> no push occurs, wb_acko stays 0.
